// File: rtl/ct_mmu_dutlb_huge_ctrl_pkg.sv
// ct_mmu_pkg
//   Shared MMU constants for the huge-page data uTLB controller: default
//   field widths, the huge-page level width and the refill FSM state encoding.
package ct_mmu_pkg;

    localparam int CT_VPN_WIDTH   = 27;
    localparam int CT_PPN_WIDTH   = 28;
    localparam int CT_FLG_WIDTH   = 14;
    localparam int CT_ASID_WIDTH  = 16;
    localparam int HUGE_LVL_WIDTH = 9;

    typedef enum logic [1:0] {
        HUGE_IDLE = 2'd0,
        HUGE_REQ  = 2'd1,
        HUGE_WAIT = 2'd2,
        HUGE_UPD  = 2'd3
    } huge_state_e;

endpackage

// File: rtl/ct_mmu_dutlb_huge_ctrl_if.sv
// ct_mmu_dutlb_huge_ctrl_if
//   Refill channel between the huge-page uTLB controller and the jTLB.
//   master : uTLB side, drives utlb_jtlb_req / utlb_jtlb_vpn
//   slave  : jTLB side, drives grant, response valid/kind and refill payload
interface ct_mmu_dutlb_huge_ctrl_if
    import ct_mmu_pkg::*;
#(
    parameter int VPN_WIDTH  = CT_VPN_WIDTH,
    parameter int PPN_WIDTH  = CT_PPN_WIDTH,
    parameter int FLG_WIDTH  = CT_FLG_WIDTH,
    parameter int ASID_WIDTH = CT_ASID_WIDTH
) ();

    logic                  utlb_jtlb_req;
    logic [VPN_WIDTH-1:0]  utlb_jtlb_vpn;
    logic                  jtlb_utlb_grant;
    logic                  jtlb_utlb_resp_vld;
    logic                  jtlb_utlb_resp_huge;
    logic                  jtlb_utlb_resp_fault;
    logic [PPN_WIDTH-1:0]  jtlb_utlb_resp_ppn;
    logic [FLG_WIDTH-1:0]  jtlb_utlb_resp_flg;
    logic [ASID_WIDTH-1:0] jtlb_utlb_resp_asid;
    logic                  jtlb_utlb_resp_g;

    modport master (
        output utlb_jtlb_req, utlb_jtlb_vpn,
        input  jtlb_utlb_grant, jtlb_utlb_resp_vld, jtlb_utlb_resp_huge,
               jtlb_utlb_resp_fault, jtlb_utlb_resp_ppn, jtlb_utlb_resp_flg,
               jtlb_utlb_resp_asid, jtlb_utlb_resp_g
    );

    modport slave (
        input  utlb_jtlb_req, utlb_jtlb_vpn,
        output jtlb_utlb_grant, jtlb_utlb_resp_vld, jtlb_utlb_resp_huge,
               jtlb_utlb_resp_fault, jtlb_utlb_resp_ppn, jtlb_utlb_resp_flg,
               jtlb_utlb_resp_asid, jtlb_utlb_resp_g
    );

endinterface

// File: rtl/ct_mmu_dutlb_huge_ctrl_victim.sv
// ct_mmu_dutlb_huge_victim
//   Victim picker for the huge-entry array. Lowest-index invalid entry wins;
//   when every entry is valid the round-robin pointer rr names the victim.
//   Ports: utlb_clk, cpurst (sync, active-high), entry_vld, advance (an
//   update is being committed this cycle), clr (global clear), victim (one-hot).
module ct_mmu_dutlb_huge_victim #(
    parameter int ENTRY_NUM = 4
) (
    input  logic                 utlb_clk,
    input  logic                 cpurst,
    input  logic [ENTRY_NUM-1:0] entry_vld,
    input  logic                 advance,
    input  logic                 clr,
    output logic [ENTRY_NUM-1:0] victim
);

    localparam int RR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    logic [RR_W-1:0]      rr;
    logic [ENTRY_NUM-1:0] inv_vec;
    logic [ENTRY_NUM-1:0] low_inv;
    logic [ENTRY_NUM-1:0] rr_onehot;
    logic                 all_vld;

    assign inv_vec   = ~entry_vld;
    assign low_inv   = inv_vec & (-inv_vec);
    assign all_vld   = &entry_vld;
    assign rr_onehot = ENTRY_NUM'(1) << rr;
    assign victim    = all_vld ? rr_onehot : low_inv;

    // rr only moves when it actually supplied the victim; ENTRY_NUM is a
    // power of two so the natural wrap of rr is the modulo.
    always_ff @(posedge utlb_clk) begin
        if (cpurst || clr) begin
            rr <= '0;
        end else if (advance && all_vld) begin
            rr <= rr + RR_W'(1);
        end
    end

endmodule

// File: rtl/ct_mmu_dutlb_huge_ctrl.sv
// ct_mmu_dutlb_huge_ctrl
//   Hit resolution and one-at-a-time jTLB refill sequencing for the 1 GiB
//   huge-page data uTLB entries.
//   Ports: utlb_clk, cpurst (sync, active-high); lookup ports lsu_req0/1_vld,
//   utlb_req_vpn0/1, entry_vld, entry_hit0/1; clear pulses regs_utlb_clr,
//   tlboper_utlb_clr; jtlb refill channel (master modport); outputs
//   huge_hit0/1, huge_sel0/1, utlb_entry_upd + registered update payload,
//   huge_refill_busy, huge_refill_fault.
module ct_mmu_dutlb_huge_ctrl
    import ct_mmu_pkg::*;
#(
    parameter int ENTRY_NUM  = 4,
    parameter int VPN_WIDTH  = CT_VPN_WIDTH,
    parameter int PPN_WIDTH  = CT_PPN_WIDTH,
    parameter int FLG_WIDTH  = CT_FLG_WIDTH,
    parameter int ASID_WIDTH = CT_ASID_WIDTH
) (
    input  logic                  utlb_clk,
    input  logic                  cpurst,
    input  logic                  lsu_req0_vld,
    input  logic                  lsu_req1_vld,
    input  logic [VPN_WIDTH-1:0]  utlb_req_vpn0,
    input  logic [VPN_WIDTH-1:0]  utlb_req_vpn1,
    input  logic [ENTRY_NUM-1:0]  entry_vld,
    input  logic [ENTRY_NUM-1:0]  entry_hit0,
    input  logic [ENTRY_NUM-1:0]  entry_hit1,
    input  logic                  regs_utlb_clr,
    input  logic                  tlboper_utlb_clr,
    ct_mmu_dutlb_huge_ctrl_if.master jtlb,
    output logic                  huge_hit0,
    output logic                  huge_hit1,
    output logic [ENTRY_NUM-1:0]  huge_sel0,
    output logic [ENTRY_NUM-1:0]  huge_sel1,
    output logic [ENTRY_NUM-1:0]  utlb_entry_upd,
    output logic [VPN_WIDTH-1:0]  utlb_upd_vpn,
    output logic [PPN_WIDTH-1:0]  utlb_upd_ppn,
    output logic [FLG_WIDTH-1:0]  utlb_upd_flg,
    output logic [ASID_WIDTH-1:0] utlb_upd_asid,
    output logic                  utlb_upd_g,
    output logic                  huge_refill_busy,
    output logic                  huge_refill_fault
);

    huge_state_e           state;
    huge_state_e           state_nxt;
    logic [ENTRY_NUM-1:0]  hit_vec0;
    logic [ENTRY_NUM-1:0]  hit_vec1;
    logic [ENTRY_NUM-1:0]  victim;
    logic [VPN_WIDTH-1:0]  refill_vpn;
    logic                  miss0;
    logic                  miss1;
    logic                  clr;
    logic                  drop;
    logic                  drop_eff;
    logic                  resp_acc;
    logic                  resp_take;
    logic                  upd_cyc;

    assign hit_vec0  = entry_hit0 & entry_vld;
    assign hit_vec1  = entry_hit1 & entry_vld;
    assign huge_hit0 = lsu_req0_vld & (|hit_vec0);
    assign huge_hit1 = lsu_req1_vld & (|hit_vec1);
    assign huge_sel0 = hit_vec0 & (-hit_vec0);
    assign huge_sel1 = hit_vec1 & (-hit_vec1);
    assign miss0     = lsu_req0_vld & ~(|hit_vec0);
    assign miss1     = lsu_req1_vld & ~(|hit_vec1);

    assign clr      = regs_utlb_clr | tlboper_utlb_clr;
    // A clear landing in the same cycle as the response must still discard it.
    assign drop_eff = drop | clr;

    // A response in REQ only counts when the grant arrives with it.
    assign resp_acc  = jtlb.jtlb_utlb_resp_vld &
                       ((state == HUGE_WAIT) || ((state == HUGE_REQ) && jtlb.jtlb_utlb_grant));
    assign resp_take = resp_acc & jtlb.jtlb_utlb_resp_huge & ~jtlb.jtlb_utlb_resp_fault & ~drop_eff;
    assign upd_cyc   = (state == HUGE_UPD);

    always_comb begin
        state_nxt = state;
        unique case (state)
            HUGE_IDLE: if (miss0 || miss1) state_nxt = HUGE_REQ;
            HUGE_REQ:  if (jtlb.jtlb_utlb_grant) begin
                           if (resp_acc) state_nxt = resp_take ? HUGE_UPD : HUGE_IDLE;
                           else          state_nxt = HUGE_WAIT;
                       end
            HUGE_WAIT: if (resp_acc) state_nxt = resp_take ? HUGE_UPD : HUGE_IDLE;
            HUGE_UPD:  state_nxt = HUGE_IDLE;
            default:   state_nxt = HUGE_IDLE;
        endcase
    end

    always_ff @(posedge utlb_clk) begin
        if (cpurst) begin
            state             <= HUGE_IDLE;
            drop              <= 1'b0;
            huge_refill_fault <= 1'b0;
            refill_vpn        <= '0;
            utlb_upd_vpn      <= '0;
            utlb_upd_ppn      <= '0;
            utlb_upd_flg      <= '0;
            utlb_upd_asid     <= '0;
            utlb_upd_g        <= 1'b0;
        end else begin
            state             <= state_nxt;
            huge_refill_fault <= resp_acc & jtlb.jtlb_utlb_resp_fault & ~drop_eff;
            if (state_nxt == HUGE_IDLE) begin
                drop <= 1'b0;
            end else if (clr && (state == HUGE_REQ || state == HUGE_WAIT)) begin
                drop <= 1'b1;
            end
            // Port 0 wins when both ports miss in the same cycle.
            if (state == HUGE_IDLE && (miss0 || miss1)) begin
                refill_vpn <= miss0 ? utlb_req_vpn0 : utlb_req_vpn1;
            end
            if (resp_acc) begin
                utlb_upd_vpn  <= refill_vpn;
                utlb_upd_ppn  <= jtlb.jtlb_utlb_resp_ppn;
                utlb_upd_flg  <= jtlb.jtlb_utlb_resp_flg;
                utlb_upd_asid <= jtlb.jtlb_utlb_resp_asid;
                utlb_upd_g    <= jtlb.jtlb_utlb_resp_g;
            end
        end
    end

    ct_mmu_dutlb_huge_victim #(
        .ENTRY_NUM (ENTRY_NUM)
    ) u_victim (
        .utlb_clk  (utlb_clk),
        .cpurst    (cpurst),
        .entry_vld (entry_vld),
        .advance   (upd_cyc & ~clr),
        .clr       (clr),
        .victim    (victim)
    );

    assign utlb_entry_upd     = (upd_cyc && !clr) ? victim : '0;
    assign jtlb.utlb_jtlb_req = (state == HUGE_REQ);
    assign jtlb.utlb_jtlb_vpn = refill_vpn;
    assign huge_refill_busy   = (state != HUGE_IDLE);

endmodule

// File: tb/tb_ct_mmu_dutlb_huge_ctrl.sv
// tb_ct_mmu_dutlb_huge_ctrl
//   Self-checking bench for ct_mmu_dutlb_huge_ctrl. Update strobes and fault
//   pulses are predicted into a queue when the response is driven and popped
//   by a monitor when the DUT produces them.
module tb_ct_mmu_dutlb_huge_ctrl;
    import ct_mmu_pkg::*;

    logic        utlb_clk = 1'b0;
    logic        cpurst;
    logic        lsu_req0_vld, lsu_req1_vld;
    logic [26:0] utlb_req_vpn0, utlb_req_vpn1;
    logic [3:0]  entry_vld, entry_hit0, entry_hit1;
    logic        regs_utlb_clr, tlboper_utlb_clr;
    logic        huge_hit0, huge_hit1;
    logic [3:0]  huge_sel0, huge_sel1, utlb_entry_upd;
    logic [26:0] utlb_upd_vpn;
    logic [27:0] utlb_upd_ppn;
    logic [13:0] utlb_upd_flg;
    logic [15:0] utlb_upd_asid;
    logic        utlb_upd_g, huge_refill_busy, huge_refill_fault;

    typedef struct {
        int          cyc;
        logic [3:0]  upd;
        logic        fault;
        logic [26:0] vpn;
        logic [27:0] ppn;
        logic [13:0] flg;
        logic [15:0] asid;
        logic        g;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   m_rr = 0;
    logic mon_en = 1'b0;

    always #5 utlb_clk = ~utlb_clk;
    always @(posedge utlb_clk) cyc <= cyc + 1;

    ct_mmu_dutlb_huge_ctrl_if jtlb_if ();

    ct_mmu_dutlb_huge_ctrl dut (
        .utlb_clk          (utlb_clk),
        .cpurst            (cpurst),
        .lsu_req0_vld      (lsu_req0_vld),
        .lsu_req1_vld      (lsu_req1_vld),
        .utlb_req_vpn0     (utlb_req_vpn0),
        .utlb_req_vpn1     (utlb_req_vpn1),
        .entry_vld         (entry_vld),
        .entry_hit0        (entry_hit0),
        .entry_hit1        (entry_hit1),
        .regs_utlb_clr     (regs_utlb_clr),
        .tlboper_utlb_clr  (tlboper_utlb_clr),
        .jtlb              (jtlb_if),
        .huge_hit0         (huge_hit0),
        .huge_hit1         (huge_hit1),
        .huge_sel0         (huge_sel0),
        .huge_sel1         (huge_sel1),
        .utlb_entry_upd    (utlb_entry_upd),
        .utlb_upd_vpn      (utlb_upd_vpn),
        .utlb_upd_ppn      (utlb_upd_ppn),
        .utlb_upd_flg      (utlb_upd_flg),
        .utlb_upd_asid     (utlb_upd_asid),
        .utlb_upd_g        (utlb_upd_g),
        .huge_refill_busy  (huge_refill_busy),
        .huge_refill_fault (huge_refill_fault)
    );

    // Scoreboard consumer: every strobe or fault pulse must match the head.
    always @(negedge utlb_clk) begin
        exp_t e;
        if (mon_en && (utlb_entry_upd !== 4'b0000 || huge_refill_fault !== 1'b0)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: upd=%b fault=%b at cycle %0d, required no event",
                         utlb_entry_upd, huge_refill_fault, cyc);
            end else begin
                e = exp_q.pop_front();
                if (utlb_entry_upd !== e.upd || huge_refill_fault !== e.fault || cyc != e.cyc ||
                    (e.upd != 4'b0000 &&
                     {utlb_upd_vpn, utlb_upd_ppn, utlb_upd_flg, utlb_upd_asid, utlb_upd_g} !==
                     {e.vpn, e.ppn, e.flg, e.asid, e.g})) begin
                    n_err++;
                    $display("FAIL refill_event: got upd=%b fault=%b cyc=%0d vpn=%h ppn=%h flg=%h asid=%h g=%b, required upd=%b fault=%b cyc=%0d vpn=%h ppn=%h flg=%h asid=%h g=%b",
                             utlb_entry_upd, huge_refill_fault, cyc, utlb_upd_vpn, utlb_upd_ppn,
                             utlb_upd_flg, utlb_upd_asid, utlb_upd_g,
                             e.upd, e.fault, e.cyc, e.vpn, e.ppn, e.flg, e.asid, e.g);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge utlb_clk);
        #1;
    endtask

    function automatic logic [3:0] model_victim(input logic [3:0] vld, input int rr);
        logic [3:0] r;
        logic [3:0] one;
        one = 4'b0001;
        r = '0;
        if (vld == 4'b1111) begin
            r = one << rr;
        end else begin
            for (int i = 3; i >= 0; i--) if (!vld[i]) r = one << i;
        end
        return r;
    endfunction

    // Drives one miss -> grant -> response sequence and predicts its outcome.
    // clr_at: 0 none, 1 clear in REQ, 2 clear in first WAIT cycle, 3 clear in UPD.
    task automatic refill(input logic req0, input logic req1,
                          input logic [26:0] v0, input logic [26:0] v1,
                          input int gdly, input int rdly,
                          input logic huge, input logic fault,
                          input logic [27:0] ppn, input logic [13:0] flg,
                          input logic [15:0] asid, input logic g, input int clr_at);
        exp_t e;
        int   c0;
        step();
        lsu_req0_vld = req0; lsu_req1_vld = req1;
        utlb_req_vpn0 = v0;  utlb_req_vpn1 = v1;
        entry_hit0 = '0;     entry_hit1 = '0;
        c0 = cyc;
        step();
        lsu_req0_vld = 1'b0; lsu_req1_vld = 1'b0;
        repeat (gdly) step();
        jtlb_if.jtlb_utlb_grant = 1'b1;
        if (clr_at == 1) regs_utlb_clr = 1'b1;
        step();
        jtlb_if.jtlb_utlb_grant = 1'b0;
        regs_utlb_clr = 1'b0;
        if (clr_at == 2) tlboper_utlb_clr = 1'b1;
        for (int i = 0; i < rdly; i++) begin
            step();
            tlboper_utlb_clr = 1'b0;
        end
        jtlb_if.jtlb_utlb_resp_vld   = 1'b1;
        jtlb_if.jtlb_utlb_resp_huge  = huge;
        jtlb_if.jtlb_utlb_resp_fault = fault;
        jtlb_if.jtlb_utlb_resp_ppn   = ppn;
        jtlb_if.jtlb_utlb_resp_flg   = flg;
        jtlb_if.jtlb_utlb_resp_asid  = asid;
        jtlb_if.jtlb_utlb_resp_g     = g;
        e.cyc = c0 + 3 + gdly + rdly;
        e.vpn = req0 ? v0 : v1;
        e.ppn = ppn; e.flg = flg; e.asid = asid; e.g = g;
        if (clr_at == 0 && huge && !fault) begin
            e.upd = model_victim(entry_vld, m_rr);
            e.fault = 1'b0;
            exp_q.push_back(e);
            if (entry_vld == 4'b1111) m_rr = (m_rr + 1) % 4;
        end else if (clr_at == 0 && fault) begin
            e.upd = 4'b0000;
            e.fault = 1'b1;
            exp_q.push_back(e);
        end
        if (clr_at != 0) m_rr = 0;
        step();
        jtlb_if.jtlb_utlb_resp_vld = 1'b0;
        tlboper_utlb_clr = 1'b0;
        if (clr_at == 3) begin
            regs_utlb_clr = 1'b1;
            step();
            regs_utlb_clr = 1'b0;
        end
    endtask

    task automatic test_reset();
        cpurst = 1'b1;
        repeat (2) step();
        n_vec++; if (huge_refill_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", huge_refill_busy); end
        n_vec++; if (jtlb_if.utlb_jtlb_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b, required 0", jtlb_if.utlb_jtlb_req); end
        n_vec++; if (utlb_entry_upd !== 4'b0000) begin n_err++; $display("FAIL reset_upd: got %b, required 0000", utlb_entry_upd); end
        n_vec++; if (huge_refill_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b, required 0", huge_refill_fault); end
        n_vec++; if (jtlb_if.utlb_jtlb_vpn !== 27'h0) begin n_err++; $display("FAIL reset_vpn: got %h, required 0", jtlb_if.utlb_jtlb_vpn); end
        n_vec++; if (utlb_upd_ppn !== 28'h0) begin n_err++; $display("FAIL reset_ppn: got %h, required 0", utlb_upd_ppn); end
        cpurst = 1'b0;
        m_rr = 0;
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_hit();
        entry_vld = 4'b1111;
        entry_hit0 = 4'b0110; entry_hit1 = 4'b1000;
        lsu_req0_vld = 1'b1;  lsu_req1_vld = 1'b1;
        #1;
        n_vec++; if (huge_sel0 !== 4'b0010) begin n_err++; $display("FAIL hit_sel0: got %b, required 0010", huge_sel0); end
        n_vec++; if (huge_hit0 !== 1'b1) begin n_err++; $display("FAIL hit_hit0: got %b, required 1", huge_hit0); end
        n_vec++; if (huge_sel1 !== 4'b1000) begin n_err++; $display("FAIL hit_sel1: got %b, required 1000", huge_sel1); end
        n_vec++; if (huge_hit1 !== 1'b1) begin n_err++; $display("FAIL hit_hit1: got %b, required 1", huge_hit1); end
        entry_vld = 4'b1101;
        #1;
        n_vec++; if (huge_sel0 !== 4'b0100) begin n_err++; $display("FAIL hit_sel0_invalid_skip: got %b, required 0100", huge_sel0); end
        step();
        n_vec++; if (huge_refill_busy !== 1'b0 || jtlb_if.utlb_jtlb_req !== 1'b0) begin
            n_err++; $display("FAIL hit_no_refill: got busy=%b req=%b, required 0 0", huge_refill_busy, jtlb_if.utlb_jtlb_req); end
        lsu_req0_vld = 1'b0; lsu_req1_vld = 1'b0;
        entry_hit0 = 4'b0010;
        #1;
        n_vec++; if (huge_hit0 !== 1'b0 || huge_sel0 !== 4'b0000) begin
            n_err++; $display("FAIL hit_invalid_entry: got hit=%b sel=%b, required 0 0000", huge_hit0, huge_sel0); end
        entry_hit0 = '0; entry_hit1 = '0;
        step();
    endtask

    task automatic test_dual_miss();
        entry_vld = 4'b0000;
        refill(1'b1, 1'b1, 27'h1000000, 27'h2000000, 0, 0, 1'b1, 1'b0, 28'hABC, 14'h155, 16'h1234, 1'b1, 0);
        repeat (2) step();
        n_vec++; if (jtlb_if.utlb_jtlb_vpn !== 27'h1000000) begin n_err++; $display("FAIL dual_miss_vpn: got %h, required 1000000", jtlb_if.utlb_jtlb_vpn); end
        n_vec++; if (huge_refill_busy !== 1'b0) begin n_err++; $display("FAIL dual_miss_idle: got busy=%b, required 0", huge_refill_busy); end
        entry_vld = 4'b0001;
        refill(1'b0, 1'b1, 27'h0123456, 27'h0ABCDEF, 1, 2, 1'b1, 1'b0, 28'h7654321, 14'h2AA, 16'hBEEF, 1'b0, 0);
        repeat (2) step();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL dual_miss_pending: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_rr();
        entry_vld = 4'b1111;
        regs_utlb_clr = 1'b1;
        step();
        regs_utlb_clr = 1'b0;
        m_rr = 0;
        n_vec++; if (huge_refill_busy !== 1'b0) begin n_err++; $display("FAIL rr_clear_idle: got busy=%b, required 0", huge_refill_busy); end
        for (int i = 0; i < 6; i++) begin
            refill(1'b1, 1'b0, 27'($urandom), 27'h0, i % 2, i % 3, 1'b1, 1'b0,
                   28'($urandom), 14'($urandom), 16'($urandom), i[0], 0);
            step();
        end
        repeat (2) step();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_pending: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_clear();
        entry_vld = 4'b1111;
        refill(1'b1, 1'b0, 27'h0000111, 27'h0, 0, 2, 1'b1, 1'b0, 28'h111, 14'h1, 16'h1, 1'b0, 2);
        n_vec++; if (huge_refill_busy !== 1'b0) begin n_err++; $display("FAIL clear_wait_idle: got busy=%b, required 0", huge_refill_busy); end
        repeat (2) step();
        refill(1'b1, 1'b0, 27'h0000222, 27'h0, 1, 0, 1'b1, 1'b0, 28'h222, 14'h2, 16'h2, 1'b0, 1);
        n_vec++; if (huge_refill_busy !== 1'b0) begin n_err++; $display("FAIL clear_req_idle: got busy=%b, required 0", huge_refill_busy); end
        repeat (2) step();
        refill(1'b1, 1'b0, 27'h0000333, 27'h0, 0, 1, 1'b1, 1'b1, 28'h333, 14'h3, 16'h3, 1'b0, 2);
        repeat (2) step();
        refill(1'b1, 1'b0, 27'h0000444, 27'h0, 0, 0, 1'b1, 1'b0, 28'h444, 14'h4, 16'h4, 1'b1, 0);
        repeat (2) step();
        refill(1'b1, 1'b0, 27'h0000555, 27'h0, 0, 0, 1'b1, 1'b0, 28'h555, 14'h5, 16'h5, 1'b1, 3);
        repeat (2) step();
        refill(1'b1, 1'b0, 27'h0000666, 27'h0, 0, 0, 1'b1, 1'b0, 28'h666, 14'h6, 16'h6, 1'b1, 0);
        repeat (2) step();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL clear_pending: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_fault();
        entry_vld = 4'b0011;
        refill(1'b1, 1'b0, 27'h0ABC000, 27'h0, 0, 0, 1'b1, 1'b1, 28'h1, 14'h0, 16'h0, 1'b0, 0);
        repeat (2) step();
        refill(1'b0, 1'b1, 27'h0, 27'h0DEF000, 1, 1, 1'b0, 1'b1, 28'h2, 14'h0, 16'h0, 1'b0, 0);
        repeat (2) step();
        refill(1'b1, 1'b0, 27'h0123000, 27'h0, 0, 1, 1'b0, 1'b0, 28'h3, 14'h0, 16'h0, 1'b0, 0);
        n_vec++; if (huge_refill_busy !== 1'b0) begin n_err++; $display("FAIL nonhuge_idle: got busy=%b, required 0", huge_refill_busy); end
        repeat (2) step();
        refill(1'b1, 1'b0, 27'h0456000, 27'h0, 0, 0, 1'b1, 1'b0, 28'h4, 14'h7, 16'h8, 1'b1, 0);
        repeat (2) step();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fault_pending: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_hold_grant_reset();
        entry_vld = 4'b1111;
        step();
        lsu_req0_vld = 1'b1; utlb_req_vpn0 = 27'h3C0FFEE; entry_hit0 = '0;
        step();
        lsu_req0_vld = 1'b0;
        lsu_req1_vld = 1'b1; utlb_req_vpn1 = 27'h5555555; entry_hit1 = '0;
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (jtlb_if.utlb_jtlb_req !== 1'b1 || jtlb_if.utlb_jtlb_vpn !== 27'h3C0FFEE) begin
                n_err++; $display("FAIL hold_req: got req=%b vpn=%h, required 1 3c0ffee", jtlb_if.utlb_jtlb_req, jtlb_if.utlb_jtlb_vpn); end
            step();
        end
        n_vec++; if (huge_hit1 !== 1'b0) begin n_err++; $display("FAIL busy_lookup_hit1: got %b, required 0", huge_hit1); end
        jtlb_if.jtlb_utlb_grant = 1'b1;
        step();
        jtlb_if.jtlb_utlb_grant = 1'b0;
        lsu_req1_vld = 1'b0;
        n_vec++; if (jtlb_if.utlb_jtlb_req !== 1'b0 || huge_refill_busy !== 1'b1) begin
            n_err++; $display("FAIL grant_drop_req: got req=%b busy=%b, required 0 1", jtlb_if.utlb_jtlb_req, huge_refill_busy); end
        cpurst = 1'b1;
        step();
        cpurst = 1'b0;
        m_rr = 0;
        n_vec++; if (huge_refill_busy !== 1'b0 || jtlb_if.utlb_jtlb_req !== 1'b0 || utlb_entry_upd !== 4'b0000 || huge_refill_fault !== 1'b0) begin
            n_err++; $display("FAIL midwait_reset_ctrl: got busy=%b req=%b upd=%b fault=%b, required 0 0 0000 0",
                              huge_refill_busy, jtlb_if.utlb_jtlb_req, utlb_entry_upd, huge_refill_fault); end
        n_vec++; if (jtlb_if.utlb_jtlb_vpn !== 27'h0 || utlb_upd_vpn !== 27'h0 || utlb_upd_ppn !== 28'h0) begin
            n_err++; $display("FAIL midwait_reset_payload: got vpn=%h upd_vpn=%h upd_ppn=%h, required 0 0 0",
                              jtlb_if.utlb_jtlb_vpn, utlb_upd_vpn, utlb_upd_ppn); end
        jtlb_if.jtlb_utlb_resp_vld   = 1'b1;
        jtlb_if.jtlb_utlb_resp_huge  = 1'b1;
        jtlb_if.jtlb_utlb_resp_fault = 1'b1;
        step();
        jtlb_if.jtlb_utlb_resp_vld = 1'b0;
        repeat (2) step();
        n_vec++; if (huge_refill_busy !== 1'b0) begin n_err++; $display("FAIL stale_resp_idle: got busy=%b, required 0", huge_refill_busy); end
        refill(1'b1, 1'b0, 27'h0777777, 27'h0, 0, 0, 1'b1, 1'b0, 28'h9999, 14'h11, 16'h22, 1'b1, 0);
        repeat (2) step();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL reset_pending: got %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        cpurst = 1'b1;
        lsu_req0_vld = 1'b0; lsu_req1_vld = 1'b0;
        utlb_req_vpn0 = '0;  utlb_req_vpn1 = '0;
        entry_vld = '0; entry_hit0 = '0; entry_hit1 = '0;
        regs_utlb_clr = 1'b0; tlboper_utlb_clr = 1'b0;
        jtlb_if.jtlb_utlb_grant      = 1'b0;
        jtlb_if.jtlb_utlb_resp_vld   = 1'b0;
        jtlb_if.jtlb_utlb_resp_huge  = 1'b0;
        jtlb_if.jtlb_utlb_resp_fault = 1'b0;
        jtlb_if.jtlb_utlb_resp_ppn   = '0;
        jtlb_if.jtlb_utlb_resp_flg   = '0;
        jtlb_if.jtlb_utlb_resp_asid  = '0;
        jtlb_if.jtlb_utlb_resp_g     = 1'b0;
        test_reset();
        test_hit();
        test_dual_miss();
        test_rr();
        test_clear();
        test_fault();
        test_hold_grant_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
